// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between the UART controller and the serializer
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    modport master (output tx_data, tx_data_valid, input tx_data_ready);
    modport slave (input tx_data, tx_data_valid, output tx_data_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 (even parity)
module uart_tx_serializer #(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 115200
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave s,
    output logic     tx_pin
);
    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CW    = CYCLE < 2 ? 1 : $clog2(CYCLE);
    if (CYCLE < 2) begin : g_cycle_chk
        $error("uart_tx_serializer: CLK_FRE/BAUD_RATE gives fewer than 2 clocks per bit");
    end
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      sh, sh_n;
    logic            ready, ready_n, pin_n, bit_end;
    assign s.tx_data_ready = ready;
    assign bit_end = cnt == CW'(CYCLE - 1);
    // the data register rotates, so after 8 bits it holds the original byte for parity
    always_comb begin
        state_n = state;
        sh_n    = sh;
        idx_n   = idx;
        cnt_n   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
        case (state)
            IDLE: if (s.tx_data_valid && ready) begin
                state_n = START;
                sh_n    = s.tx_data;
            end
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                sh_n  = {sh[0], sh[7:1]};
                idx_n = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (idx == 3'd7) state_n = PARITY;
`else
                if (idx == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_n = STOP;
`endif
            STOP: if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ready_n = state_n == IDLE;
        pin_n   = state_n == START ? 1'b0 :
                  state_n == DATA  ? sh_n[0] :
`ifdef UART_TX_PARITY_EN
                  state_n == PARITY ? ^sh_n :
`endif
                  1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            ready  <= 1'b0;
            tx_pin <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sh     <= sh_n;
            ready  <= ready_n;
            tx_pin <= pin_n;
        end
    end
endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-wide UART transmitter: accepts one byte per valid/ready handshake from the UART controller and shifts it out on a single serial line as 8N1 (optionally 8E1). It is the serializer that drives the controller's `tx_data_ready` and consumes its `o_tx_data` / `o_tx_data_valid`. It sits between the controller and the board TX pin.

## Interface
- `CLK_FRE`, default 27: system clock frequency in MHz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `tx_data`  in  8  byte to send; sampled only on the accept cycle.
- `tx_data_valid`  in  1  sender holds a valid byte.
- `tx_data_ready`  out  1  serializer idle and able to accept a byte.
- `tx_pin`  out  1  serial output; idle level 1.

## Operation
- Bit period: `CYCLE = CLK_FRE*1000000/BAUD_RATE`, integer-truncated. For example, 27 MHz at 115200 gives 234.
  - `CYCLE < 2` is illegal; an elaboration-time check flags it.
  - The cycle counter is `$clog2(CYCLE)` bits wide, counts 0..CYCLE-1, then wraps to 0.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after CYCLE clocks.
  - DATA → PARITY (if enabled) or STOP after 8 bit periods.
  - PARITY → STOP after CYCLE clocks.
  - STOP → IDLE after CYCLE clocks.
  - Unreachable encodings → IDLE.
- Accept: a byte is accepted when `tx_data_valid && tx_data_ready` at a rising edge. At that edge:
  - `tx_data` is latched into the shift register.
  - The state goes to START.
  - `tx_data_ready` drops to 0 from the next cycle.
- Line levels by state:
  - START: `tx_pin`=0.
  - DATA: bit index 0..7, LSB first. A 3-bit bit counter increments at each bit-period end.
  - STOP: `tx_pin`=1.
- Ready rules:
  - `tx_data_ready` is registered and is 1 only in IDLE.
  - It is never high for two consecutive cycles while `tx_data_valid` is high. A sender that holds valid therefore gets exactly one acceptance per frame.
  - `tx_data` changes while not in IDLE are ignored.
- `tx_data_valid` low in IDLE: stay in IDLE, `tx_pin`=1, ready=1, indefinitely.
- Reset, at any time including mid-frame:
  - Immediately: `tx_pin`=1, `tx_data_ready`=0, state=IDLE, counters=0, shift register=0.
  - The frame in progress is aborted; no partial stop bit is emitted.

## Timing
- Reset values: `tx_pin`=1, `tx_data_ready`=0.
- `tx_data_ready` goes to 1 on the first rising edge after `rst` deasserts.
- Accept to start bit: `tx_pin` falls on the edge after the accept edge, a latency of 1 clock.
- Each line bit is held for exactly CYCLE clocks.
- Frame length from first start-bit clock to end of stop bit: 10·CYCLE clocks, or 11·CYCLE with parity.
- `tx_data_ready` is low for the whole frame. It rises on the clock following the last stop-bit clock.
- Back-to-back sending with valid held high:
  - The next byte is accepted on the single IDLE cycle.
  - The next start bit begins 1 clock later.
  - So consecutive frames are separated by CYCLE+1 clocks of stop level.
- Simultaneous reset and accept: reset wins; no byte is accepted.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity, the XOR of the 8 latched data bits, for CYCLE clocks.
  - Frame is 11·CYCLE clocks.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic; STOP follows data bit 7 directly.
  - Frame is 10·CYCLE clocks.

## Test plan
- Reset check, with `CLK_FRE`=1 and `BAUD_RATE`=100000 (CYCLE=10):
  - Assert `rst` for 5 clocks, then release → `tx_pin`=1 throughout; `tx_data_ready`=0 during reset and 1 one clock after release.
- Single byte, `tx_data`=8'h55 with a 1-clock valid pulse:
  - `tx_pin` goes low 1 clock after accept.
  - Then data bits 1,0,1,0,1,0,1,0 (LSB first), each 10 clocks.
  - Then 10 clocks high; ready stays low for 100 clocks.
- Back-to-back, valid held high with 8'hA3 then 8'h0F:
  - Exactly two acceptances.
  - The second start bit begins 11 clocks after the first frame's stop bit starts.
  - Decoded bytes are A3 and 0F.
- Ignored data: change `tx_data` from 8'h00 to 8'hFF mid-frame → the transmitted byte remains 8'h00.
- Mid-frame reset:
  - Assert `rst` during data bit 3 → `tx_pin`=1 immediately.
  - After release, a new byte 8'h81 transmits cleanly.
- Parity, with `UART_TX_PARITY_EN` defined:
  - 8'h07 → parity bit 1, frame 110 clocks.
  - 8'h03 → parity bit 0.
